sqrt_pipe: RTL and testbench

- Parametrised, fully pipelined, non-restoring integer/fixed-point square root. One radix-2 stage per result bit.
- Adds to the earlier fixed-width sqrt: fractional result bits, a corrected remainder output, valid/ready flow control with backpressure, and asynchronous reset.
- Sits between a producer of unsigned magnitudes (e.g. sum-of-squares accumulator) and downstream consumers that may stall.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_pipe_if.sv | 27 ++
 rtl/sqrt_stage.sv | 58 +++++
 rtl/sqrt_pipe.sv | 82 ++++++++
 tb/tb_sqrt_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Width and stage-count helpers shared by the sqrt pipeline, its stages and its interface.
package sqrt_pkg;

  // Root width: half the radicand bits plus the fractional extension.
  function automatic int unsigned q_width(input int unsigned w, input int unsigned f);
    return w / 2 + f;
  endfunction

  // Signed partial remainder carried between stages.
  function automatic int unsigned r_width(input int unsigned w, input int unsigned f);
    return q_width(w, f) + 2;
  endfunction

  // Radicand after left-extension by the fractional zero pairs.
  function automatic int unsigned d_width(input int unsigned w, input int unsigned f);
    return w + 2 * f;
  endfunction

  function automatic int unsigned n_stages(input int unsigned w, input int unsigned f);
    return q_width(w, f);
  endfunction

endpackage

// File: rtl/sqrt_pipe_if.sv
// Valid/ready streaming bundle for sqrt_pipe: radicand in, root and remainder out.
interface sqrt_pipe_if
  import sqrt_pkg::*;
#(
  parameter int unsigned G_WIDTH = 8,
  parameter int unsigned G_FRAC  = 0
);
  localparam int unsigned Q_W = q_width(G_WIDTH, G_FRAC);

  logic               in_valid;
  logic               in_ready;
  logic [G_WIDTH-1:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic [Q_W-1:0]     root_out;
  logic [Q_W:0]       rem_out;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, root_out, rem_out
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, root_out, rem_out
  );
endinterface

// File: rtl/sqrt_stage.sv
// One registered non-restoring square-root iteration (one root bit per stage).
module sqrt_stage #(
  parameter int unsigned Q_W = 4,
  parameter int unsigned D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic [Q_W-1:0] q_i,
  input  logic [Q_W+1:0] r_i,
  input  logic [D_W-1:0] d_i,
  input  logic           v_i,
  output logic [Q_W-1:0] q_o,
  output logic [Q_W+1:0] r_o,
  output logic [D_W-1:0] d_o,
  output logic           v_o
);
  localparam int unsigned R_W = Q_W + 2;

  logic           sign;
  logic [R_W-1:0] x, y, alu;
  logic [Q_W-1:0] q_d, q_q;
  logic [R_W-1:0] r_d, r_q;
  logic [D_W-1:0] d_d, d_q;
  logic           v_q;
  logic           unused_r;

  // The bit below the sign is always shifted out: |r| never needs it once scaled by 4.
  assign unused_r = r_i[R_W-2];

  always_comb begin
    sign = r_i[R_W-1];
    x    = {r_i[R_W-3:0], d_i[D_W-1 -: 2]};
    y    = {q_i, sign, 1'b1};
    alu  = sign ? (x + y) : (x - y);
    q_d  = {q_i[Q_W-2:0], ~alu[R_W-1]};
    r_d  = alu;
    d_d  = {d_i[D_W-3:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    v_q <= 1'b0;
    else if (en_i) v_q <= v_i;
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
    end
  end

  assign q_o = q_q;
  assign r_o = r_q;
  assign d_o = d_q;
  assign v_o = v_q;
endmodule

// File: rtl/sqrt_pipe.sv
// Fully pipelined fixed-point square root with remainder correction and global-stall flow control.
module sqrt_pipe
  import sqrt_pkg::*;
#(
  parameter int unsigned G_WIDTH = 8,
  parameter int unsigned G_FRAC  = 0
) (
  input  logic clk,
  input  logic rst_n,
  sqrt_pipe_if.slave bus
);
  localparam int unsigned Q_W   = q_width(G_WIDTH, G_FRAC);
  localparam int unsigned R_W   = r_width(G_WIDTH, G_FRAC);
  localparam int unsigned D_W   = d_width(G_WIDTH, G_FRAC);
  localparam int unsigned N_STG = n_stages(G_WIDTH, G_FRAC);

  logic           adv;
  logic [Q_W-1:0] q_s [0:N_STG];
  logic [R_W-1:0] r_s [0:N_STG];
  logic [D_W-1:0] d_s [0:N_STG];
  logic           v_s [0:N_STG];

  logic [R_W-1:0] rem_full;
  logic [Q_W:0]   rem_d, rem_q;
  logic [Q_W-1:0] root_d, root_q;
  logic           vld_d, vld_q;
  logic           unused_bits;

  // Single stall signal for the whole pipe: everything moves or nothing does.
  assign adv          = bus.out_ready || !vld_q;
  assign bus.in_ready = adv;

  assign q_s[0] = '0;
  assign r_s[0] = '0;
  assign d_s[0] = D_W'(bus.data_in) << (2 * G_FRAC);
  assign v_s[0] = bus.in_valid && adv;

  for (genvar i = 0; i < N_STG; i++) begin : g_stg
    sqrt_stage #(
      .Q_W (Q_W),
      .D_W (D_W)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (adv),
      .q_i   (q_s[i]),
      .r_i   (r_s[i]),
      .d_i   (d_s[i]),
      .v_i   (v_s[i]),
      .q_o   (q_s[i+1]),
      .r_o   (r_s[i+1]),
      .d_o   (d_s[i+1]),
      .v_o   (v_s[i+1])
    );
  end

  // A negative final remainder is pulled back by {q,1}; the result is never negative.
  always_comb begin
    rem_full = r_s[N_STG][R_W-1] ? (r_s[N_STG] + R_W'({q_s[N_STG], 1'b1})) : r_s[N_STG];
    rem_d    = rem_full[Q_W:0];
    root_d   = q_s[N_STG];
    vld_d    = v_s[N_STG];
  end

  assign unused_bits = ^{rem_full[R_W-1], d_s[N_STG]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (adv) begin
      vld_q  <= vld_d;
      root_q <= root_d;
      rem_q  <= rem_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.root_out  = root_q;
  assign bus.rem_out   = rem_q;
endmodule

// File: tb/tb_sqrt_pipe.sv
// Scoreboard bench for sqrt_pipe at three configurations: (8,0), (8,2) and (16,4).
module tb_sqrt_pipe;

  typedef struct {
    longint root;
    longint rem;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b0;
  int          out8_cnt = 0;
  exp_t        sb8[$], sb8f[$], sb16[$];
  exp_t        e8, e8f, e16;

  always @(posedge clk) cyc <= cyc + 1;

  sqrt_pipe_if #(.G_WIDTH(8),  .G_FRAC(0)) if8  ();
  sqrt_pipe_if #(.G_WIDTH(8),  .G_FRAC(2)) if8f ();
  sqrt_pipe_if #(.G_WIDTH(16), .G_FRAC(4)) if16 ();

  sqrt_pipe #(.G_WIDTH(8),  .G_FRAC(0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  sqrt_pipe #(.G_WIDTH(8),  .G_FRAC(2)) u_dut8f (.clk(clk), .rst_n(rst_n), .bus(if8f.slave));
  sqrt_pipe #(.G_WIDTH(16), .G_FRAC(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint lo = 0;
    longint hi = 64'd1 << 21;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  function automatic exp_t mk_exp(input longint data, input int frac, input int c);
    exp_t   e;
    longint n = data << (2 * frac);
    e.root = isqrt(n);
    e.rem  = n - e.root * e.root;
    e.cyc  = c;
    return e;
  endfunction

  task automatic cmp_out(input string nm, input exp_t e, input logic [63:0] root,
                         input logic [63:0] rem, input int lat);
    check_eq({nm, "_root"}, root, e.root);
    check_eq({nm, "_rem"}, rem, e.rem);
    check_eq({nm, "_rem_le_2root"}, 64'(rem <= 2 * root), 1);
    if (lat != 0) check_eq({nm, "_latency"}, cyc - e.cyc, lat);
  endtask

  // Output transfers pop the scoreboard; accepted inputs push onto it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if8.out_valid && if8.out_ready) begin
        check_eq("d8_sb_nonempty", 64'(sb8.size() != 0), 1);
        if (sb8.size() != 0) begin
          e8 = sb8.pop_front();
          cmp_out("d8", e8, 64'(if8.root_out), 64'(if8.rem_out), lat_chk ? 5 : 0);
        end
        out8_cnt++;
      end
      if (if8.out_valid && !if8.out_ready) check_eq("d8_stall_in_ready", 64'(if8.in_ready), 0);
      if (if8.in_valid && if8.in_ready) sb8.push_back(mk_exp(64'(if8.data_in), 0, cyc));

      if (if8f.out_valid && if8f.out_ready) begin
        check_eq("d8f_sb_nonempty", 64'(sb8f.size() != 0), 1);
        if (sb8f.size() != 0) begin
          e8f = sb8f.pop_front();
          cmp_out("d8f", e8f, 64'(if8f.root_out), 64'(if8f.rem_out), 0);
        end
      end
      if (if8f.in_valid && if8f.in_ready) sb8f.push_back(mk_exp(64'(if8f.data_in), 2, cyc));

      if (if16.out_valid && if16.out_ready) begin
        check_eq("d16_sb_nonempty", 64'(sb16.size() != 0), 1);
        if (sb16.size() != 0) begin
          e16 = sb16.pop_front();
          cmp_out("d16", e16, 64'(if16.root_out), 64'(if16.rem_out), 0);
        end
      end
      if (if16.out_valid && !if16.out_ready) check_eq("d16_stall_in_ready", 64'(if16.in_ready), 0);
      if (if16.in_valid && if16.in_ready) sb16.push_back(mk_exp(64'(if16.data_in), 4, cyc));
    end
  end

  task automatic send8(input logic [7:0] v);
    bit acc = 1'b0;
    if8.in_valid = 1'b1;
    if8.data_in  = v;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk); acc = if8.in_ready;
      @(posedge clk); #1;
    end
    check_eq("d8_send_accepted", 64'(acc), 1);
    if8.in_valid = 1'b0;
  endtask

  task automatic send8f(input logic [7:0] v);
    bit acc = 1'b0;
    if8f.in_valid = 1'b1;
    if8f.data_in  = v;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk); acc = if8f.in_ready;
      @(posedge clk); #1;
    end
    check_eq("d8f_send_accepted", 64'(acc), 1);
    if8f.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] v);
    bit acc = 1'b0;
    if16.in_valid = 1'b1;
    if16.data_in  = v;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk); acc = if16.in_ready;
      @(posedge clk); #1;
    end
    check_eq("d16_send_accepted", 64'(acc), 1);
    if16.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (sb8.size() + sb8f.size() + sb16.size()) != 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check_eq("drain_sb_empty", 64'(sb8.size() + sb8f.size() + sb16.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  rnd_done;
    rst_n = 1'b0;
    if8.in_valid  = 1'b0; if8.data_in  = '0; if8.out_ready  = 1'b1;
    if8f.in_valid = 1'b0; if8f.data_in = '0; if8f.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.data_in = '0; if16.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    check_eq("rst_out_valid", 64'(if8.out_valid), 0);
    check_eq("rst_root", 64'(if8.root_out), 0);
    check_eq("rst_rem", 64'(if8.rem_out), 0);
    check_eq("rst_out_valid16", 64'(if16.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream, latency 5 per item
    lat_chk = 1'b1;
    send8(8'd0); send8(8'd15); send8(8'd16); send8(8'd255);
    drain();

    // Fractional root
    send8f(8'd2); send8f(8'd255); send8f(8'd0);
    drain();

    // Bubbles between two valid inputs
    base = out8_cnt;
    send8(8'd9);
    repeat (2) begin @(posedge clk); #1; end
    send8(8'd100);
    drain();
    check_eq("bubble_out_count", 64'(out8_cnt - base), 2);

    // Backpressure: toggle out_ready, then hold it low for 7 cycles
    lat_chk = 1'b0;
    base = out8_cnt;
    fork
      for (int v = 1; v <= 20; v++) send8(8'(v));
      begin
        repeat (6) begin @(posedge clk); #1; if8.out_ready = !if8.out_ready; end
        @(posedge clk); #1; if8.out_ready = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        if8.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_out_count", 64'(out8_cnt - base), 20);

    // Random stream with 50% out_ready
    rnd_done = 1'b0;
    fork
      begin
        send16(16'd0); send16(16'hFFFF);
        for (int n = 0; n < 10000; n++) send16(16'($urandom_range(0, 65535)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1; if16.out_ready = 1'($urandom_range(0, 1)); end
        if16.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with results in flight
    if8.out_ready = 1'b0;
    send8(8'd200); send8(8'd201); send8(8'd202);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("prerst_out_valid", 64'(if8.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 64'(if8.out_valid), 0);
    sb8.delete();
    base = out8_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    lat_chk = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check_eq("postrst_no_stale", 64'(out8_cnt - base), 0);
    send8(8'd49);
    drain();
    check_eq("postrst_out_count", 64'(out8_cnt - base), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
